// File: rtl/calculadora_multicanal.sv
// Multi-channel calculator: a bank of NUM_ACC accumulators selected per command,
// single-cycle add/sub/load/clear/show ops and an iterative shift-add multiply.
module calculadora_multicanal #(
  parameter int WIDTH    = 8,
  parameter int NUM_ACC  = 4,
  parameter int SATURATE = 0,
  localparam int CW      = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] entrada,
  input  logic [2:0]       codigo,
  input  logic [CW-1:0]    canal,
  input  logic             valido,
  output logic             pronto,
  output logic [WIDTH-1:0] saida,
  output logic             saida_valida,
  output logic             estouro,
  output logic             zero
);

  localparam int CNTW = $clog2(WIDTH);

  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_d;

  logic [WIDTH-1:0]   acc [NUM_ACC];
  logic [WIDTH-1:0]   acc_cur;
  logic               ch_ok, accept, op_ok, mul_start, mul_done;

  // multiply datapath: latched multiplicand/multiplier/channel, running product
  logic [2*WIDTH-1:0] mcand, prod, prod_fin;
  logic [WIDTH-1:0]   mplier;
  logic [CNTW-1:0]    cnt;
  logic [CW-1:0]      ch_l;
  logic               mul_ovf;
  logic [WIDTH-1:0]   mul_res;

  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   add_res, sub_res;

  // write/output controls for the current cycle
  logic               wr_en, out_en, ovf_we, ovf_val;
  logic [CW-1:0]      wr_ch;
  logic [WIDTH-1:0]   wr_val, out_val;

  assign pronto    = (state == IDLE);
  assign ch_ok     = ({1'b0, canal} < (CW+1)'(NUM_ACC));
  assign accept    = valido && pronto;
  // out-of-range channels are accepted but behave as the reserved code
  assign op_ok     = accept && ch_ok;
  assign mul_start = op_ok && (codigo == 3'b100);
  assign mul_done  = (state == MUL) && (cnt == CNTW'(WIDTH-1));

  // read mux for the selected accumulator; out-of-range reads as zero
  always_comb begin
    acc_cur = '0;
    for (int i = 0; i < NUM_ACC; i++)
      if (ch_ok && canal == CW'(i)) acc_cur = acc[i];
  end

  assign sum      = {1'b0, acc_cur} + {1'b0, entrada};
  assign diff     = {1'b0, acc_cur} - {1'b0, entrada};
  assign add_res  = (SATURATE != 0 && sum[WIDTH])  ? '1 : sum[WIDTH-1:0];
  assign sub_res  = (SATURATE != 0 && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];

  // last iteration folds in the final partial product combinationally
  assign prod_fin = prod + (mplier[0] ? mcand : '0);
  assign mul_ovf  = |prod_fin[2*WIDTH-1:WIDTH];
  assign mul_res  = (SATURATE != 0 && mul_ovf) ? '1 : prod_fin[WIDTH-1:0];

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // next-state: enter MUL on an accepted multiply, leave after WIDTH iterations
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (mul_start) state_d = MUL;
      MUL:     if (mul_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // decode of the accumulator write, result and flag update for this cycle
  always_comb begin
    wr_en   = 1'b0;
    wr_ch   = canal;
    wr_val  = '0;
    out_en  = 1'b0;
    out_val = '0;
    ovf_we  = 1'b0;
    ovf_val = 1'b0;
    if (mul_done) begin
      wr_en = 1'b1; wr_ch = ch_l; wr_val = mul_res;
      out_en = 1'b1; out_val = mul_res;
      ovf_we = 1'b1; ovf_val = mul_ovf;
    end else if (op_ok) begin
      case (codigo)
        3'b000: begin out_en = 1'b1; out_val = entrada; end
        3'b001: begin
          wr_en = 1'b1; wr_val = add_res; out_en = 1'b1; out_val = add_res;
          ovf_we = 1'b1; ovf_val = sum[WIDTH];
        end
        3'b010: begin
          wr_en = 1'b1; wr_val = sub_res; out_en = 1'b1; out_val = sub_res;
          ovf_we = 1'b1; ovf_val = diff[WIDTH];
        end
        3'b011: begin out_en = 1'b1; out_val = acc_cur; end
        3'b101: begin wr_en = 1'b1; out_en = 1'b1; ovf_we = 1'b1; end
        3'b110: begin
          wr_en = 1'b1; wr_val = entrada; out_en = 1'b1; out_val = entrada;
          ovf_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // accumulator bank: only the addressed entry is written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_ACC; i++)
        if (wr_ch == CW'(i)) acc[i] <= wr_val;
    end
  end

  // result register and flags; zero tracks only published results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      saida        <= '0;
      saida_valida <= 1'b0;
      estouro      <= 1'b0;
      zero         <= 1'b1;
    end else begin
      saida_valida <= out_en;
      if (out_en) begin
        saida <= out_val;
        zero  <= (out_val == '0);
      end
      if (ovf_we) estouro <= ovf_val;
    end
  end

  // shift-add multiplier: operands latched at accept, one bit per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      ch_l   <= '0;
    end else if (mul_start) begin
      mcand  <= {{WIDTH{1'b0}}, acc_cur};
      mplier <= entrada;
      prod   <= '0;
      cnt    <= '0;
      ch_l   <= canal;
    end else if (state == MUL) begin
      prod   <= prod_fin;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_calculadora_multicanal.sv
// Directed bench: wrap-around and saturating instances driven in lockstep.
module tb_calculadora_multicanal;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] entrada;
  logic [2:0] codigo;
  logic [1:0] canal;
  logic       valido;

  logic       w_pronto, w_sv, w_est, w_zero;
  logic [7:0] w_saida;
  logic       s_pronto, s_sv, s_est, s_zero;
  logic [7:0] s_saida;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  calculadora_multicanal #(.WIDTH(8), .NUM_ACC(4), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .entrada(entrada), .codigo(codigo), .canal(canal),
    .valido(valido), .pronto(w_pronto), .saida(w_saida), .saida_valida(w_sv),
    .estouro(w_est), .zero(w_zero));

  calculadora_multicanal #(.WIDTH(8), .NUM_ACC(4), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .entrada(entrada), .codigo(codigo), .canal(canal),
    .valido(valido), .pronto(s_pronto), .saida(s_saida), .saida_valida(s_sv),
    .estouro(s_est), .zero(s_zero));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // check both instances' result/pulse/flags at once
  task automatic chk_w(input string tag, input int sa, input int sv, input int es, input int ze);
    check({tag, " w.saida"}, 32'(w_saida), 32'(sa));
    check({tag, " w.valid"}, 32'(w_sv), 32'(sv));
    check({tag, " w.estouro"}, 32'(w_est), 32'(es));
    check({tag, " w.zero"}, 32'(w_zero), 32'(ze));
  endtask

  task automatic chk_s(input string tag, input int sa, input int sv, input int es, input int ze);
    check({tag, " s.saida"}, 32'(s_saida), 32'(sa));
    check({tag, " s.valid"}, 32'(s_sv), 32'(sv));
    check({tag, " s.estouro"}, 32'(s_est), 32'(es));
    check({tag, " s.zero"}, 32'(s_zero), 32'(ze));
  endtask

  // one-cycle command; outputs sampled 1 time unit after the accepting edge
  task automatic cmd(input logic [2:0] c, input logic [1:0] ch, input logic [7:0] d);
    codigo = c; canal = ch; entrada = d; valido = 1'b1;
    @(posedge clk); #1;
    valido = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // multiply: accept, then wait the remaining 8 edges to completion
  task automatic mul(input logic [1:0] ch, input logic [7:0] d);
    cmd(3'b100, ch, d);
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valido = 1'b0; codigo = '0; canal = '0; entrada = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_w("reset", 0, 0, 0, 1);
    chk_s("reset", 0, 0, 0, 1);
    check("reset pronto", 32'(w_pronto), 32'd1);
    rst = 1'b0;

    // load 200 then add 100: wraps to 44 / clamps to 255
    cmd(3'b110, 2'd0, 8'd200);
    chk_w("load200", 200, 1, 0, 0);
    cmd(3'b001, 2'd0, 8'd100);
    chk_w("add100", 44, 1, 1, 0);
    chk_s("add100", 255, 1, 1, 0);
    idle_cycle();
    check("add single pulse w", 32'(w_sv), 32'd0);
    check("add single pulse s", 32'(s_sv), 32'd0);

    // sub 1 from a cleared channel
    cmd(3'b010, 2'd1, 8'd1);
    chk_w("sub1", 255, 1, 1, 0);
    chk_s("sub1", 0, 1, 1, 1);

    // channel independence
    cmd(3'b110, 2'd2, 8'd5);
    cmd(3'b110, 2'd3, 8'd7);
    cmd(3'b011, 2'd2, 8'd0);
    chk_w("show ch2", 5, 1, 0, 0);
    cmd(3'b011, 2'd3, 8'd0);
    chk_w("show ch3", 7, 1, 0, 0);
    cmd(3'b011, 2'd0, 8'd0);
    check("show ch0 w", 32'(w_saida), 32'd44);
    check("show ch0 s", 32'(s_saida), 32'd255);
    cmd(3'b011, 2'd1, 8'd0);
    check("show ch1 w", 32'(w_saida), 32'd255);
    check("show ch1 s", 32'(s_saida), 32'd0);

    // 12 * 11 with a competing command held on the inputs during MUL
    cmd(3'b110, 2'd0, 8'd12);
    codigo = 3'b100; canal = 2'd0; entrada = 8'd11; valido = 1'b1;
    @(posedge clk); #1;
    check("mul accept pronto", 32'(w_pronto), 32'd0);
    check("mul accept pulse", 32'(w_sv), 32'd0);
    codigo = 3'b110; canal = 2'd0; entrada = 8'd99;
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      check("mul busy pronto", 32'(w_pronto), 32'd0);
      check("mul busy pulse", 32'(w_sv), 32'd0);
    end
    @(posedge clk); #1;
    valido = 1'b0;
    chk_w("mul 12x11", 132, 1, 0, 0);
    chk_s("mul 12x11", 132, 1, 0, 0);
    check("mul done pronto", 32'(w_pronto), 32'd1);
    cmd(3'b011, 2'd0, 8'd0);
    check("ignored load", 32'(w_saida), 32'd132);

    // 20 * 20 = 400: low byte 144, overflow
    cmd(3'b110, 2'd0, 8'd20);
    mul(2'd0, 8'd20);
    chk_w("mul 20x20", 144, 1, 1, 0);
    chk_s("mul 20x20", 255, 1, 1, 0);

    // reset in the middle of a multiply
    cmd(3'b110, 2'd0, 8'd3);
    cmd(3'b100, 2'd0, 8'd5);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_w("mid-mul rst", 0, 0, 0, 1);
    check("mid-mul rst pronto", 32'(w_pronto), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      check("post-rst no pulse", 32'(w_sv), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      cmd(3'b011, 2'(i), 8'd0);
      check("post-rst acc w", 32'(w_saida), 32'd0);
      check("post-rst acc s", 32'(s_saida), 32'd0);
    end

    // estouro held by show; reserved code holds saida with no pulse
    cmd(3'b010, 2'd2, 8'd1);
    chk_w("sub ch2", 255, 1, 1, 0);
    cmd(3'b000, 2'd1, 8'h5A);
    chk_w("show 5A", 32'h5A, 1, 1, 0);
    chk_s("show 5A", 32'h5A, 1, 1, 0);
    cmd(3'b111, 2'd1, 8'h33);
    chk_w("reserved", 32'h5A, 0, 1, 0);
    cmd(3'b011, 2'd1, 8'd0);
    chk_w("ch1 unchanged", 0, 1, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
